// File: rtl/at_pkg.sv
// rtl/at_pkg.sv - shared state encoding and character constants for the AT command buffer
package at_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_HI = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_SEND_CR = 3'd3,
    ST_SEND_LF = 3'd4,
    ST_DONE    = 3'd5
  } atState_e;

  localparam logic [7:0] AT_CR  = 8'h0D;
  localparam logic [7:0] AT_LF  = 8'h0A;
  localparam logic [7:0] AT_NUL = 8'h00;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-event rising-edge detector for a host level signal
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic inQ;

  always_ff @(posedge clock) begin
    if (reset) inQ <= 1'b0;
    else       inQ <= in;
  end

  assign rise = in & ~inQ;

endmodule

// File: rtl/at_command_buffer.sv
// rtl/at_command_buffer.sv - buffers host AT text as char pairs and streams it bytewise to UART TX
module at_command_buffer
  import at_pkg::*;
#(
  parameter int MAX_PAIRS   = 16,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [15:0]                  pair_in,
  input  logic                         load,
  input  logic                         send,
  input  logic                         clear,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic [$clog2(MAX_PAIRS):0]   pair_count,
  output logic                         overflow,
  output logic                         done
);

  localparam int PW = $clog2(MAX_PAIRS);
  localparam int CW = PW + 1;
  localparam atState_e   TAIL_STATE = APPEND_CRLF ? ST_SEND_CR : ST_DONE;
  localparam logic [7:0] TAIL_DATA  = APPEND_CRLF ? AT_CR : AT_NUL;

  logic loadRise, sendRise, clearRise;
  logic [15:0] pairBuf [MAX_PAIRS];
  atState_e state;
  logic [PW-1:0] rdPtr, nextPtr;
  logic [15:0] curPair, nextPair;
  logic lastPair, loadAccept;

  rise_detect uLoadRise  (.clock(clock), .reset(reset), .in(load),  .rise(loadRise));
  rise_detect uSendRise  (.clock(clock), .reset(reset), .in(send),  .rise(sendRise));
  rise_detect uClearRise (.clock(clock), .reset(reset), .in(clear), .rise(clearRise));

  assign nextPtr    = rdPtr + 1'b1;
  assign curPair    = pairBuf[rdPtr];
  assign nextPair   = pairBuf[nextPtr];
  assign lastPair   = (({1'b0, rdPtr} + 1'b1) == pair_count);
  assign loadAccept = loadRise && (pair_count < CW'(MAX_PAIRS));
  assign busy       = (state != ST_IDLE);

  // Plain register array with no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && !clearRise && loadAccept)
      pairBuf[pair_count[PW-1:0]] <= pair_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      rdPtr      <= '0;
      pair_count <= '0;
      overflow   <= 1'b0;
      tx_data    <= AT_NUL;
      tx_valid   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clearRise) begin
            pair_count <= '0;
            overflow   <= 1'b0;
          end else begin
            if (loadAccept)    pair_count <= pair_count + 1'b1;
            else if (loadRise) overflow   <= 1'b1;
            // A same-cycle load is already counted, so it is part of this send.
            if (sendRise) begin
              rdPtr <= '0;
              if (pair_count == '0 && !loadAccept) begin
                state    <= TAIL_STATE;
                tx_valid <= APPEND_CRLF;
                tx_data  <= TAIL_DATA;
              end else begin
                state    <= ST_SEND_HI;
                tx_valid <= 1'b1;
                tx_data  <= (pair_count == '0) ? pair_in[15:8] : pairBuf[0][15:8];
              end
            end
          end
        end
        ST_SEND_HI: if (tx_ready) begin
          if (curPair[7:0] != AT_NUL) begin
            state   <= ST_SEND_LO;
            tx_data <= curPair[7:0];
          end else if (lastPair) begin
            state    <= TAIL_STATE;
            tx_valid <= APPEND_CRLF;
            tx_data  <= TAIL_DATA;
          end else begin
            rdPtr   <= nextPtr;
            state   <= ST_SEND_HI;
            tx_data <= nextPair[15:8];
          end
        end
        ST_SEND_LO: if (tx_ready) begin
          if (lastPair) begin
            state    <= TAIL_STATE;
            tx_valid <= APPEND_CRLF;
            tx_data  <= TAIL_DATA;
          end else begin
            rdPtr   <= nextPtr;
            state   <= ST_SEND_HI;
            tx_data <= nextPair[15:8];
          end
        end
        ST_SEND_CR: if (tx_ready) begin
          state   <= ST_SEND_LF;
          tx_data <= AT_LF;
        end
        ST_SEND_LF: if (tx_ready) begin
          state    <= ST_DONE;
          tx_valid <= 1'b0;
          tx_data  <= AT_NUL;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
